memfifo_test_checker: RTL and testbench
=======================================

Name: memfifo_test_checker

Overview:
- Downstream consumer of the 128-bit FIFO read port (FWFT `DO`/`EMPTY`/`RDEN` side) in memfifo test modes.
- Checks every word against the on-chip test-data generator format: per-byte sync bit, 7-bit counter stepping by 111, per-word checksum.
- Reports lock state, word and error counters, and a sticky error-type flag, so DRAM/BRAM FIFO integrity can be checked on the board without the host.

Parameters:
- CNT_STEP, 7'd111: counter increment between consecutive data bytes (mod 128).
- CS_INIT, 14'd47: checksum accumulator start value per word.
- WORDCNT_W, 32: width of word_cnt.
- ERRCNT_W, 16: width of err_cnt.
- LOCK_LOSS, 4: consecutive bad words that drop lock (range 1..15).

Ports:
- ifclk, input, 1: single clock; all logic rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous; zeroes counters and flags, returns FSM to HUNT.
- din, input, 128: FIFO word; byte k = din[8k+7:8k], k=0 is the oldest byte.
- din_valid, input, 1: word present (!EMPTY).
- din_ready, output, 1: accept; transfer occurs when din_valid && din_ready (drives RDEN).
- locked, output, 1: checker synchronised to the stream.
- word_cnt, output, WORDCNT_W: words checked; saturates at all-ones.
- err_cnt, output, ERRCNT_W: bad words while locked; saturates at all-ones.
- err_type, output, 3: sticky; [0] sync-bit error, [1] counter error, [2] checksum error.

Behaviour:
- Reset (async, reset_n=0) and clear: din_ready=0 (reset only), locked=0, word_cnt=0, err_cnt=0, err_type=0, FSM=HUNT, pipeline valids=0.
- din_ready goes to 1 on the first ifclk edge after reset release and stays 1. It is never deasserted on back-pressure; the checker accepts one word per cycle.
- Word format:
  - byte bit7 (sync) = 1 for k in {1,3,5,7,9,11,13,14,15}, else 0.
  - Bytes 0..14, bits[6:0] = counter c_k, with c_(k+1) = c_k + CNT_STEP mod 128.
  - Byte 15, bits[6:0] = cs[6:0] ^ cs[13:7], where cs = CS_INIT + sum over k=0..14 of byte_k (8-bit value incl. sync), 14-bit wrap.
  - Counter continues across words: c_0(next) = c_14(prev) + CNT_STEP.
- Pipeline:
  - Stage 1 registers the word plus the computed checksum, sync mismatch and intra-word counter mismatch.
  - Stage 2 compares c_0 against the expected counter, then updates the FSM and outputs.
  - Outputs reflect a word exactly 2 cycles after its transfer; back-to-back words are fully pipelined.
- Expected counter exp_c: after every word processed in stage 2, set exp_c = c_14 + CNT_STEP, whether or not the word was good.
- HUNT state:
  - A word with good sync, intra-word counter and checksum goes to LOCKED; exp_c is seeded from it.
  - c_0 is not compared in HUNT.
  - Bad words stay in HUNT and do not touch err_cnt or err_type.
  - word_cnt increments for every word in both states.
- LOCKED state:
  - Word is bad if any of sync, counter (including c_0 != exp_c) or checksum fails.
  - Bad word: err_cnt+1 (saturating), OR the fault bits into err_type, bad_run+1.
  - Good word: bad_run=0.
  - When bad_run reaches LOCK_LOSS: go to HUNT, locked=0, bad_run=0.
- clear takes priority over a word finishing stage 2 in the same cycle; that word is discarded and the pipeline is flushed.
- Arithmetic: all counter math is mod 128; checksum sum is 14-bit wrap; no X on outputs after reset.

Test Plan:
- Reset, then feed the generator stream from a reset generator: word0 bytes 0..2 = 0x00, 0xEF, 0x5E. Required: locked=1 at cycle 2 after the first transfer; after 1000 words word_cnt=1000, err_cnt=0, err_type=0.
- Locked stream, flip bit7 of byte 4 in one word -> err_cnt=1, err_type=3'b001, locked stays 1. Next good word leaves err_cnt=1.
- Locked stream, drop one whole word (skip) -> c_0 mismatch on the next word: err_cnt=1, err_type[1]=1; the following words are good again, since exp_c reseeds.
- Corrupt the checksum byte in 4 consecutive words (LOCK_LOSS=4) -> err_cnt=4, err_type=3'b100, locked=0 after the 4th. The next good word relocks.
- Random din_valid gaps (50% duty) over 500 words -> word_cnt=500, err_cnt=0. Asserting clear mid-stream gives all counters 0 and locked=0 next cycle, then relock on the next good word.
- Assert reset_n=0 asynchronously mid-word (between edges) -> outputs go to their reset values immediately, without waiting for an ifclk edge; din_ready=0 until the first edge after release.

Source files
------------

// File: rtl/memfifo_test_checker.sv
// memfifo_test_checker
//   Consumes 128-bit words from the FWFT read side of the memfifo test FIFO and
//   checks each word against the on-chip test-data generator format:
//   a per-byte sync bit, a 7-bit counter that steps by CNT_STEP, and a per-word
//   checksum folded into byte 15. It reports lock state, word and error counts,
//   and sticky error-type flags, so FIFO integrity can be checked on the board.
//
// Ports
//   ifclk      : clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   clear      : synchronous clear of counters, flags, FSM and pipeline
//   din        : FIFO word, byte k = din[8k+7:8k], byte 0 is the oldest
//   din_valid  : word present (!EMPTY)
//   din_ready  : read enable, high from the first edge after reset release
//   locked     : checker is synchronised to the stream
//   word_cnt   : words checked (saturating)
//   err_cnt    : bad words seen while locked (saturating)
//   err_type   : sticky {checksum, counter, sync} error flags
module memfifo_test_checker #(
  parameter logic [6:0]  CNT_STEP  = 7'd111,
  parameter logic [13:0] CS_INIT   = 14'd47,
  parameter int          WORDCNT_W = 32,
  parameter int          ERRCNT_W  = 16,
  parameter int          LOCK_LOSS = 4
) (
  input  logic                 ifclk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [127:0]         din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 locked,
  output logic [WORDCNT_W-1:0] word_cnt,
  output logic [ERRCNT_W-1:0]  err_cnt,
  output logic [2:0]           err_type
);

  // Bytes 1,3,5,7,9,11,13,14,15 carry a set sync bit.
  localparam logic [15:0] SYNC_MASK = 16'hEAAA;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic [6:0] cs_fold(input logic [13:0] cs);
    return cs[6:0] ^ cs[13:7];
  endfunction

  function automatic logic [WORDCNT_W-1:0] sat_inc_word(input logic [WORDCNT_W-1:0] v);
    return (&v) ? v : v + WORDCNT_W'(1);
  endfunction

  function automatic logic [ERRCNT_W-1:0] sat_inc_err(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  logic ready_q;
  logic xfer;

  assign din_ready = ready_q;
  assign xfer      = din_valid && ready_q;

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= 1'b1;
  end

  // ---- stage 0 -> 1: per-word checks that need only the word itself ----
  logic [13:0] cs_sum;
  logic        sync_bad, cnt_bad, cs_bad;

  always_comb begin
    cs_sum   = CS_INIT;
    sync_bad = 1'b0;
    cnt_bad  = 1'b0;
    for (int k = 0; k < 15; k++) cs_sum = cs_sum + {6'd0, din[8*k +: 8]};
    for (int k = 0; k < 16; k++)
      if (din[8*k+7] != SYNC_MASK[k]) sync_bad = 1'b1;
    for (int k = 0; k < 14; k++)
      if (din[8*k+8 +: 7] != 7'(din[8*k +: 7] + CNT_STEP)) cnt_bad = 1'b1;
  end

  assign cs_bad = din[126:120] != cs_fold(cs_sum);

  logic       vld_p1;
  logic [6:0] c0_p1, c14_p1;
  logic       sync_bad_p1, cnt_bad_p1, cs_bad_p1;

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n)   vld_p1 <= 1'b0;
    else if (clear) vld_p1 <= 1'b0;
    else            vld_p1 <= xfer;
  end

  always_ff @(posedge ifclk) begin
    if (xfer) begin
      c0_p1       <= din[6:0];
      c14_p1      <= din[118:112];
      sync_bad_p1 <= sync_bad;
      cnt_bad_p1  <= cnt_bad;
      cs_bad_p1   <= cs_bad;
    end
  end

  // ---- stage 1 -> 2: cross-word counter check, FSM and counters ----
  logic [0:0]           state_q, state_d;
  logic [3:0]           bad_run_q, bad_run_d, bad_run_inc;
  logic [6:0]           exp_c_q, exp_c_d;
  logic [WORDCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [2:0]           err_type_q, err_type_d;
  logic [2:0]           fault;

  assign fault       = {cs_bad_p1, cnt_bad_p1 | (c0_p1 != exp_c_q), sync_bad_p1};
  assign bad_run_inc = bad_run_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    bad_run_d  = bad_run_q;
    exp_c_d    = exp_c_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_type_d = err_type_q;
    if (vld_p1) begin
      word_cnt_d = sat_inc_word(word_cnt_q);
      // Reseed on every word so a single dropped word costs one error, not a burst.
      exp_c_d    = c14_p1 + CNT_STEP;
      if (state_q == ST_HUNT) begin
        // c_0 has nothing to be compared against while hunting.
        if (!(sync_bad_p1 || cnt_bad_p1 || cs_bad_p1)) begin
          state_d   = ST_LOCKED;
          bad_run_d = 4'd0;
        end
      end else if (|fault) begin
        err_cnt_d  = sat_inc_err(err_cnt_q);
        err_type_d = err_type_q | fault;
        if (bad_run_inc == 4'(LOCK_LOSS)) begin
          state_d   = ST_HUNT;
          bad_run_d = 4'd0;
        end else begin
          bad_run_d = bad_run_inc;
        end
      end else begin
        bad_run_d = 4'd0;
      end
    end
  end

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HUNT;
      bad_run_q  <= 4'd0;
      exp_c_q    <= 7'd0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_type_q <= 3'd0;
    end else if (clear) begin
      state_q    <= ST_HUNT;
      bad_run_q  <= 4'd0;
      exp_c_q    <= 7'd0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_type_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      bad_run_q  <= bad_run_d;
      exp_c_q    <= exp_c_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_type_q <= err_type_d;
    end
  end

  assign locked   = (state_q == ST_LOCKED);
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_type = err_type_q;

endmodule

// File: tb/tb_memfifo_test_checker.sv
// Directed bench for memfifo_test_checker: drives generator-format words and
// hand-built faults, checking lock, counters and error flags.
module tb_memfifo_test_checker;

  logic         ifclk = 1'b0;
  logic         reset_n, clear;
  logic [127:0] din;
  logic         din_valid, din_ready, locked;
  logic [31:0]  word_cnt;
  logic [15:0]  err_cnt;
  logic [2:0]   err_type;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [6:0]  gc;

  // First generator word after reset, computed by hand.
  localparam logic [127:0] WORD0  = 128'hB992A334C556E778891AAB3CCD5EEF00;
  localparam logic [127:0] CSFLIP = 128'h1 << 120;

  memfifo_test_checker dut (
    .ifclk     (ifclk),
    .reset_n   (reset_n),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .locked    (locked),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt),
    .err_type  (err_type)
  );

  always #5 ifclk = ~ifclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Generator word starting at counter c0; optionally flips the sync bit of
  // byte 4 before the checksum is formed, so only the sync check trips.
  function automatic logic [127:0] gen(input logic [6:0] c0, input bit flip4);
    logic [127:0] w;
    logic [13:0]  cs;
    logic [6:0]   c;
    logic [7:0]   b;
    logic [15:0]  sm;
    sm = 16'hEAAA;
    w  = '0;
    cs = 14'd47;
    c  = c0;
    for (int k = 0; k < 15; k++) begin
      b = {sm[k], c};
      if (flip4 && k == 4) b[7] = ~b[7];
      w[8*k +: 8] = b;
      cs = cs + {6'd0, b};
      c  = c + 7'd111;
    end
    w[127:120] = {1'b1, cs[6:0] ^ cs[13:7]};
    return w;
  endfunction

  task automatic send(input logic [127:0] w);
    @(negedge ifclk);
    clear     = 1'b0;
    din       = w;
    din_valid = 1'b1;
    @(posedge ifclk);
    #1;
  endtask

  task automatic send_gen();
    send(gen(gc, 1'b0));
    gc = gc + 7'd1;
  endtask

  task automatic idle(input int n);
    @(negedge ifclk);
    clear     = 1'b0;
    din_valid = 1'b0;
    repeat (n) @(posedge ifclk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge ifclk);
    din_valid = 1'b0;
    clear     = 1'b1;
    @(posedge ifclk);
    #1;
    check("clear_locked", locked, 0);
    check("clear_word_cnt", word_cnt, 0);
    check("clear_err_cnt", err_cnt, 0);
    check("clear_err_type", err_type, 0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; gc = 7'd0;
    #12;
    check("rst_ready", din_ready, 0);
    check("rst_locked", locked, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_type", err_type, 0);
    @(negedge ifclk);
    reset_n = 1'b1;
    #1 check("ready_before_edge", din_ready, 0);
    @(posedge ifclk);
    #1 check("ready_after_edge", din_ready, 1);

    // Hand-built first word: result appears two cycles after the transfer.
    send(WORD0);
    gc = 7'd1;
    check("lat_locked_early", locked, 0);
    check("lat_cnt_early", word_cnt, 0);
    idle(1);
    check("lat_locked", locked, 1);
    check("lat_word_cnt", word_cnt, 1);

    for (int i = 1; i < 1000; i++) send_gen();
    idle(2);
    check("w1000_cnt", word_cnt, 1000);
    check("w1000_err_cnt", err_cnt, 0);
    check("w1000_err_type", err_type, 0);
    check("w1000_locked", locked, 1);

    // Sync-bit fault on byte 4.
    send(gen(gc, 1'b1));
    gc = gc + 7'd1;
    idle(1);
    check("sync_err_cnt", err_cnt, 1);
    check("sync_err_type", err_type, 3'b001);
    check("sync_locked", locked, 1);
    send_gen();
    idle(1);
    check("sync_next_err_cnt", err_cnt, 1);
    check("sync_next_locked", locked, 1);

    // Dropped word.
    do_clear();
    send_gen();
    idle(1);
    check("relock_a", locked, 1);
    gc = gc + 7'd1;
    send_gen();
    idle(1);
    check("skip_err_cnt", err_cnt, 1);
    check("skip_err_type", err_type, 3'b010);
    check("skip_locked", locked, 1);
    for (int i = 0; i < 3; i++) send_gen();
    idle(1);
    check("skip_after_err_cnt", err_cnt, 1);
    check("skip_after_locked", locked, 1);

    // Checksum corruption in LOCK_LOSS consecutive words.
    do_clear();
    send_gen();
    idle(1);
    check("relock_b", locked, 1);
    for (int i = 0; i < 3; i++) begin
      send(gen(gc, 1'b0) ^ CSFLIP);
      gc = gc + 7'd1;
    end
    idle(1);
    check("cs3_err_cnt", err_cnt, 3);
    check("cs3_locked", locked, 1);
    send(gen(gc, 1'b0) ^ CSFLIP);
    gc = gc + 7'd1;
    idle(1);
    check("cs4_err_cnt", err_cnt, 4);
    check("cs4_err_type", err_type, 3'b100);
    check("cs4_locked", locked, 0);
    send_gen();
    idle(1);
    check("cs_relock", locked, 1);
    check("cs_relock_err_cnt", err_cnt, 4);

    // Random valid gaps.
    do_clear();
    for (int i = 0; i < 500; i++) begin
      send_gen();
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);
    check("gap_word_cnt", word_cnt, 500);
    check("gap_err_cnt", err_cnt, 0);
    check("gap_locked", locked, 1);

    // Clear in the middle of a back-to-back stream.
    send_gen();
    @(negedge ifclk);
    din = gen(gc, 1'b0); gc = gc + 7'd1;
    din_valid = 1'b1;
    clear = 1'b1;
    @(posedge ifclk);
    #1;
    check("mclr_word_cnt", word_cnt, 0);
    check("mclr_locked", locked, 0);
    check("mclr_err_cnt", err_cnt, 0);
    send_gen();
    idle(1);
    check("mclr_relock", locked, 1);
    check("mclr_word_cnt_after", word_cnt, 1);

    // Asynchronous reset between edges while a word is presented.
    send_gen();
    send_gen();
    check("pre_rst_locked", locked, 1);
    @(negedge ifclk);
    din = gen(gc, 1'b0);
    din_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_word_cnt", word_cnt, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_err_type", err_type, 0);
    check("arst_ready", din_ready, 0);
    @(posedge ifclk);
    @(negedge ifclk);
    #1 reset_n = 1'b1;
    #1 check("arst_rel_ready", din_ready, 0);
    @(posedge ifclk);
    #1 check("arst_edge_ready", din_ready, 1);
    check("arst_edge_locked", locked, 0);
    din_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
